float_multiplier_flags: RTL and testbench

- Parametrised IEEE-754 binary floating-point multiplier. Exponent and fraction widths are set by parameters; the defaults give single precision, and half and double precision are also supported.
- Adds five selectable rounding modes and four IEEE exception flags.
- Keeps the team's per-operand strobe/ack stream handshake, so it drops into existing float pipelines alongside the adder and divider.
- Iterative, multi-cycle, one operation in flight.

---
 rtl/float_multiplier_flags_if.sv | 30 +++
 rtl/float_multiplier_flags.sv | 246 ++++++++++++++++++++++++
 tb/tb_float_multiplier_flags.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/float_multiplier_flags_if.sv
// Stream handshake bundle for the float multiplier: two operand channels,
// rounding mode, and the result channel with its exception flags.
interface float_multiplier_flags_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic [W-1:0] input_a;
  logic         input_a_stb;
  logic         input_a_ack;
  logic [W-1:0] input_b;
  logic         input_b_stb;
  logic         input_b_ack;
  logic [2:0]   rnd_mode;
  logic [W-1:0] output_z;
  logic         output_z_stb;
  logic         output_z_ack;
  logic [3:0]   output_flags;

  modport master (
    output input_a, input_a_stb, input_b, input_b_stb, rnd_mode, output_z_ack,
    input  input_a_ack, input_b_ack, output_z, output_z_stb, output_flags
  );

  modport slave (
    input  input_a, input_a_stb, input_b, input_b_stb, rnd_mode, output_z_ack,
    output input_a_ack, input_b_ack, output_z, output_z_stb, output_flags
  );
endinterface

// File: rtl/float_multiplier_flags.sv
// Iterative IEEE-754 multiplier with selectable rounding and {invalid, overflow,
// underflow, inexact} flags; one operation in flight.
module float_multiplier_flags #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic clk,
  input logic rst,
  float_multiplier_flags_if.slave bus
);
  // state   | meaning
  // GET_A   | accept operand A
  // GET_B   | accept operand B and rounding mode
  // UNPACK  | split fields, unbias exponents
  // SPECIAL | NaN/inf/zero shortcuts, hidden bit / denormal exponent
  // NORM_A  | normalise A mantissa
  // NORM_B  | normalise B mantissa
  // MUL     | full-width mantissa product
  // ALIGN   | extract z_m, guard, round, sticky
  // NORM_1  | left-normalise product
  // NORM_2  | right-shift into denormal range
  // ROUND   | apply rounding increment
  // PACK    | assemble result, overflow/underflow
  // PUT_Z   | present result until accepted
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int EW   = EXP_W + 2;
  localparam int PW   = 2 * (MAN_W + 1);
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic signed [EW-1:0] E_MIN  = EW'(1 - BIAS);
  localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);

  localparam logic [3:0] GET_A = 4'd0, GET_B = 4'd1, UNPACK = 4'd2, SPECIAL = 4'd3,
                         NORM_A = 4'd4, NORM_B = 4'd5, MUL = 4'd6, ALIGN = 4'd7,
                         NORM_1 = 4'd8, NORM_2 = 4'd9, ROUND = 4'd10, PACK = 4'd11,
                         PUT_Z = 4'd12;

  localparam logic [2:0] RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;

  localparam logic [W-1:0] QNAN = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic [3:0]             state;
  logic [W-1:0]           a, b;
  logic [MAN_W:0]         a_m, b_m, z_m;
  logic signed [EW-1:0]   a_e, b_e, z_e;
  logic                   z_s;
  logic [PW-1:0]          product;
  logic                   guard, round_bit, sticky, tiny, inexact;
  logic [2:0]             mode;
  logic                   a_ack, b_ack, z_stb;
  logic [W-1:0]           z_out;
  logic [3:0]             flags;

  logic a_ones, b_ones, a_nz, b_nz, a_nan, b_nan, a_snan, b_snan;
  logic a_inf, b_inf, a_zero, b_zero;
  logic grs, inc, ovf_inf;

  assign a_ones = &a[W-2:MAN_W];
  assign b_ones = &b[W-2:MAN_W];
  assign a_nz   = |a[MAN_W-1:0];
  assign b_nz   = |b[MAN_W-1:0];
  assign a_nan  = a_ones & a_nz;
  assign b_nan  = b_ones & b_nz;
  assign a_snan = a_nan & ~a[MAN_W-1];
  assign b_snan = b_nan & ~b[MAN_W-1];
  assign a_inf  = a_ones & ~a_nz;
  assign b_inf  = b_ones & ~b_nz;
  assign a_zero = ~|a[W-2:0];
  assign b_zero = ~|b[W-2:0];

  always_comb begin
    grs     = guard | round_bit | sticky;
    inc     = guard & (round_bit | sticky | z_m[0]);
    ovf_inf = 1'b1;
    case (mode)
      RTZ: begin inc = 1'b0;       ovf_inf = 1'b0; end
      RDN: begin inc = z_s & grs;  ovf_inf = z_s;  end
      RUP: begin inc = ~z_s & grs; ovf_inf = ~z_s; end
      RMM: begin inc = guard;      ovf_inf = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= GET_A;
      a         <= '0;
      b         <= '0;
      a_m       <= '0;
      b_m       <= '0;
      z_m       <= '0;
      a_e       <= '0;
      b_e       <= '0;
      z_e       <= '0;
      z_s       <= 1'b0;
      product   <= '0;
      guard     <= 1'b0;
      round_bit <= 1'b0;
      sticky    <= 1'b0;
      tiny      <= 1'b0;
      inexact   <= 1'b0;
      mode      <= '0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      z_stb     <= 1'b0;
      z_out     <= '0;
      flags     <= '0;
    end else begin
      case (state)
        GET_A: begin
          a_ack <= 1'b1;
          if (a_ack && bus.input_a_stb) begin
            a     <= bus.input_a;
            a_ack <= 1'b0;
            state <= GET_B;
          end
        end
        GET_B: begin
          b_ack <= 1'b1;
          if (b_ack && bus.input_b_stb) begin
            b     <= bus.input_b;
            mode  <= bus.rnd_mode;
            b_ack <= 1'b0;
            state <= UNPACK;
          end
        end
        UNPACK: begin
          a_m   <= {1'b0, a[MAN_W-1:0]};
          b_m   <= {1'b0, b[MAN_W-1:0]};
          a_e   <= $signed(EW'(a[W-2:MAN_W])) - E_BIAS;
          b_e   <= $signed(EW'(b[W-2:MAN_W])) - E_BIAS;
          z_s   <= a[W-1] ^ b[W-1];
          tiny  <= 1'b0;
          state <= SPECIAL;
        end
        SPECIAL: begin
          state <= PUT_Z;
          if (a_snan || b_snan) begin
            z_out <= QNAN;
            flags <= 4'b1000;
          end else if (a_nan || b_nan) begin
            z_out <= QNAN;
            flags <= 4'b0000;
          end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
            z_out <= QNAN;
            flags <= 4'b1000;
          end else if (a_inf || b_inf) begin
            z_out <= {z_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags <= 4'b0000;
          end else if (a_zero || b_zero) begin
            z_out <= {z_s, {(W-1){1'b0}}};
            flags <= 4'b0000;
          end else begin
            if (a[W-2:MAN_W] == '0) a_e <= E_MIN;
            else                    a_m[MAN_W] <= 1'b1;
            if (b[W-2:MAN_W] == '0) b_e <= E_MIN;
            else                    b_m[MAN_W] <= 1'b1;
            state <= NORM_A;
          end
        end
        NORM_A: begin
          if (a_m[MAN_W]) state <= NORM_B;
          else begin
            a_m <= a_m << 1;
            a_e <= a_e - E_ONE;
          end
        end
        NORM_B: begin
          if (b_m[MAN_W]) state <= MUL;
          else begin
            b_m <= b_m << 1;
            b_e <= b_e - E_ONE;
          end
        end
        MUL: begin
          product <= PW'(a_m) * PW'(b_m);
          z_e     <= a_e + b_e + E_ONE;
          state   <= ALIGN;
        end
        ALIGN: begin
          z_m       <= product[PW-1 -: MAN_W+1];
          guard     <= product[MAN_W];
          round_bit <= product[MAN_W-1];
          sticky    <= |product[MAN_W-2:0];
          state     <= NORM_1;
        end
        NORM_1: begin
          if (z_m[MAN_W]) state <= NORM_2;
          else begin
            z_m       <= {z_m[MAN_W-1:0], guard};
            guard     <= round_bit;
            round_bit <= 1'b0;
            z_e       <= z_e - E_ONE;
          end
        end
        NORM_2: begin
          // Tininess is decided before rounding: any denormalising shift counts.
          if (z_e < E_MIN) begin
            z_m       <= z_m >> 1;
            guard     <= z_m[0];
            round_bit <= guard;
            sticky    <= sticky | round_bit;
            z_e       <= z_e + E_ONE;
            tiny      <= 1'b1;
          end else state <= ROUND;
        end
        ROUND: begin
          inexact <= grs;
          if (inc) begin
            if (&z_m) begin
              z_m <= {1'b1, {MAN_W{1'b0}}};
              z_e <= z_e + E_ONE;
            end else z_m <= z_m + 1'b1;
          end
          state <= PACK;
        end
        PACK: begin
          state <= PUT_Z;
          if (z_e > E_BIAS) begin
            flags <= 4'b0101;
            if (ovf_inf) z_out <= {z_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else         z_out <= {z_s, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
          end else begin
            flags <= {2'b00, tiny & inexact, inexact};
            z_out <= {z_s, (z_m[MAN_W] ? EXP_W'(z_e + E_BIAS) : {EXP_W{1'b0}}),
                      z_m[MAN_W-1:0]};
          end
        end
        PUT_Z: begin
          z_stb <= 1'b1;
          if (z_stb && bus.output_z_ack) begin
            z_stb <= 1'b0;
            state <= GET_A;
          end
        end
        default: state <= GET_A;
      endcase
    end
  end

  assign bus.input_a_ack  = a_ack;
  assign bus.input_b_ack  = b_ack;
  assign bus.output_z     = z_out;
  assign bus.output_z_stb = z_stb;
  assign bus.output_flags = flags;
endmodule

// File: tb/tb_float_multiplier_flags.sv
// Scoreboard bench for float_multiplier_flags: single-precision vectors with
// hand-derived results and latencies, plus one half-precision instance.
module tb_float_multiplier_flags;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  float_multiplier_flags_if #(.EXP_W(8), .MAN_W(23)) sp_if ();
  float_multiplier_flags_if #(.EXP_W(5), .MAN_W(10)) hp_if ();

  float_multiplier_flags #(.EXP_W(8), .MAN_W(23)) dut_sp (.clk(clk), .rst(rst), .bus(sp_if.slave));
  float_multiplier_flags #(.EXP_W(5), .MAN_W(10)) dut_hp (.clk(clk), .rst(rst), .bus(hp_if.slave));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  m;
    logic [31:0] z;
    logic [3:0]  f;
    int          lat;
    int          hold;
    bit          pre;
  } vec_t;

  typedef struct {
    logic [31:0] z;
    logic [3:0]  f;
    int          lat;
    int          hold;
    bit          pre;
    int          b_cyc;
    int          id;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   errors   = 0;
  int   checks   = 0;
  int   cyc      = 0;
  bit   keep_stb = 1'b0;
  bit   mon_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic add(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m,
                     input logic [31:0] z, input logic [3:0] f, input int lat,
                     input int hold, input bit pre);
    vec_t v;
    v.a = a; v.b = b; v.m = m; v.z = z; v.f = f; v.lat = lat; v.hold = hold; v.pre = pre;
    vecs.push_back(v);
  endtask

  task automatic wait_ack(input bit which_b);
    int  n;
    logic ack;
    n = 0;
    forever begin
      @(negedge clk);
      ack = which_b ? sp_if.input_b_ack : sp_if.input_a_ack;
      if (ack === 1'b1) break;
      n++;
      if (n > 500) begin
        chk(which_b ? "ack_b_timeout" : "ack_a_timeout", {31'b0, ack}, 32'd1);
        finish_run();
      end
    end
  endtask

  task automatic run_op(input vec_t v, input int id);
    exp_t e;
    @(posedge clk); #1;
    sp_if.input_a     = v.a;
    sp_if.input_a_stb = 1'b1;
    wait_ack(1'b0);
    @(posedge clk); #1;
    if (!keep_stb) sp_if.input_a_stb = 1'b0;
    sp_if.input_b     = v.b;
    sp_if.rnd_mode    = v.m;
    sp_if.input_b_stb = 1'b1;
    wait_ack(1'b1);
    @(posedge clk); #1;
    if (!keep_stb) sp_if.input_b_stb = 1'b0;
    e.z = v.z; e.f = v.f; e.lat = v.lat; e.hold = v.hold; e.pre = v.pre;
    e.b_cyc = cyc; e.id = id;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", 32'(sb.size()), 32'd0);
  endtask

  initial begin : monitor
    exp_t e;
    int   held;
    int   lat;
    held = 0;
    sp_if.output_z_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (sp_if.output_z_stb === 1'b1) begin
        if (!mon_busy) begin
          if (sb.size() == 0) chk("spurious_out", {31'b0, sp_if.output_z_stb}, 32'd0);
          else begin
            e        = sb.pop_front();
            mon_busy = 1'b1;
            held     = 0;
            lat      = cyc - e.b_cyc;
            chk($sformatf("v%0d_latency", e.id), 32'(lat), 32'(e.lat));
          end
        end
        if (mon_busy) begin
          chk($sformatf("v%0d_z", e.id), sp_if.output_z, e.z);
          chk($sformatf("v%0d_flags", e.id), {28'b0, sp_if.output_flags}, {28'b0, e.f});
          held++;
          if (held > e.hold) sp_if.output_z_ack = 1'b1;
        end
      end else begin
        mon_busy = 1'b0;
        sp_if.output_z_ack = (sb.size() != 0) && sb[0].pre;
      end
    end
  end

  initial begin : main
    int n;
    int t0;
    sp_if.input_a = '0; sp_if.input_a_stb = 1'b0;
    sp_if.input_b = '0; sp_if.input_b_stb = 1'b0;
    sp_if.rnd_mode = 3'd0;
    hp_if.input_a = '0; hp_if.input_a_stb = 1'b0;
    hp_if.input_b = '0; hp_if.input_b_stb = 1'b0;
    hp_if.rnd_mode = 3'd0; hp_if.output_z_ack = 1'b1;

    //    a             b             m     z             f        lat hold pre
    add(32'h40400000, 32'h40000000, 3'd0, 32'h40C00000, 4'b0000, 12, 0,  1'b0);
    add(32'h3FC00000, 32'h3FC00000, 3'd0, 32'h40100000, 4'b0000, 11, 20, 1'b0);
    add(32'h7F800000, 32'h00000000, 3'd0, 32'hFFC00000, 4'b1000, 3,  0,  1'b1);
    add(32'h7FA00000, 32'h3F800000, 3'd0, 32'hFFC00000, 4'b1000, 3,  0,  1'b0);
    add(32'h7FC00001, 32'h3F800000, 3'd0, 32'hFFC00000, 4'b0000, 3,  0,  1'b0);
    add(32'h7F800000, 32'hC0000000, 3'd0, 32'hFF800000, 4'b0000, 3,  0,  1'b1);
    add(32'h00000000, 32'hC0A00000, 3'd0, 32'h80000000, 4'b0000, 3,  0,  1'b0);
    add(32'h7F7FFFFF, 32'h40000000, 3'd0, 32'h7F800000, 4'b0101, 12, 0,  1'b0);
    add(32'h7F7FFFFF, 32'h40000000, 3'd1, 32'h7F7FFFFF, 4'b0101, 12, 0,  1'b0);
    add(32'hFF7FFFFF, 32'h40000000, 3'd2, 32'hFF800000, 4'b0101, 12, 0,  1'b0);
    add(32'hFF7FFFFF, 32'h40000000, 3'd3, 32'hFF7FFFFF, 4'b0101, 12, 0,  1'b0);
    add(32'h00000001, 32'h3F000000, 3'd0, 32'h00000000, 4'b0011, 59, 0,  1'b0);
    add(32'h00000001, 32'h3F000000, 3'd3, 32'h00000001, 4'b0011, 59, 0,  1'b0);
    add(32'h00000001, 32'h3F000000, 3'd4, 32'h00000001, 4'b0011, 59, 0,  1'b0);
    add(32'h00000001, 32'hBF000000, 3'd2, 32'h80000001, 4'b0011, 59, 0,  1'b0);
    add(32'h00000001, 32'h3F800000, 3'd0, 32'h00000001, 4'b0000, 58, 0,  1'b0);
    add(32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 4'b0001, 12, 0,  1'b0);
    add(32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 4'b0001, 12, 0,  1'b0);
    add(32'h3F800001, 32'h3F800001, 3'd7, 32'h3F800002, 4'b0001, 12, 0,  1'b0);
    add(32'hC0000000, 32'h40400000, 3'd1, 32'hC0C00000, 4'b0000, 12, 0,  1'b0);

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_ack", {31'b0, sp_if.input_a_ack}, 32'd0);
    chk("rst_b_ack", {31'b0, sp_if.input_b_ack}, 32'd0);
    chk("rst_z_stb", {31'b0, sp_if.output_z_stb}, 32'd0);
    chk("rst_z", sp_if.output_z, 32'd0);
    chk("rst_flags", {28'b0, sp_if.output_flags}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], i);
    drain();

    keep_stb = 1'b1;
    for (int i = 0; i < 8; i++) run_op(vecs[i], 100 + i);
    sp_if.input_a_stb = 1'b0;
    sp_if.input_b_stb = 1'b0;
    keep_stb = 1'b0;
    drain();

    run_op(vecs[7], 200);
    drain();
    run_op(vecs[0], 201);
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midop_rst_z", sp_if.output_z, 32'd0);
    chk("midop_rst_flags", {28'b0, sp_if.output_flags}, 32'd0);
    chk("midop_rst_z_stb", {31'b0, sp_if.output_z_stb}, 32'd0);
    chk("midop_rst_a_ack", {31'b0, sp_if.input_a_ack}, 32'd0);
    chk("midop_rst_b_ack", {31'b0, sp_if.input_b_ack}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    run_op(vecs[0], 202);
    drain();

    @(posedge clk); #1;
    hp_if.input_a = 16'h3E00;
    hp_if.input_a_stb = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (hp_if.input_a_ack !== 1'b1 && n < 100);
    @(posedge clk); #1;
    hp_if.input_a_stb = 1'b0;
    hp_if.input_b = 16'h3E00;
    hp_if.input_b_stb = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (hp_if.input_b_ack !== 1'b1 && n < 100);
    @(posedge clk); #1;
    t0 = cyc;
    hp_if.input_b_stb = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (hp_if.output_z_stb !== 1'b1 && n < 200);
    chk("half_stb", {31'b0, hp_if.output_z_stb}, 32'd1);
    chk("half_latency", 32'(cyc - t0), 32'd11);
    chk("half_z", {16'b0, hp_if.output_z}, 32'h00004080);
    chk("half_flags", {28'b0, hp_if.output_flags}, 32'd0);
    repeat (3) @(posedge clk);

    finish_run();
  end
endmodule
